fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL take parameters from cpuPkg: PC_WIDTH (PC width), INSTR_WIDTH (instruction width), RESET_PC (PC value after reset, default 0).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  asynchronous, active-low reset
  imem_req  out  1  instruction-memory read request this cycle
  imem_addr  out  PC_WIDTH  read address, valid when imem_req=1
  imem_rdata  in  INSTR_WIDTH  read data, valid exactly 1 cycle after a request
  redirect_valid  in  1  branch taken or jump: load redirect_pc, squash fetched work
  redirect_pc  in  PC_WIDTH  target PC from branch resolution (next_pc)
  stall  in  1  hold fetch: issue no new requests (hazard, FIFO wait)
  if_valid  out  1  if_instr/if_pc hold a valid instruction for decode
  if_instr  out  INSTR_WIDTH  fetched instruction
  if_pc  out  PC_WIDTH  address of if_instr
  if_ready  in  1  decode accepts; transfer when if_valid && if_ready

Function
REQ-003 SHALL hold a fetch PC register; imem_addr = fetch PC.
REQ-004 SHALL assert imem_req when not stall, not redirect_valid, and (buffered entries + in-flight requests) < 2.
REQ-005 SHALL increment fetch PC by 1, modulo 2^PC_WIDTH, in each cycle imem_req=1; PC SHALL wrap from 2^PC_WIDTH-1 to 0.
REQ-006 SHALL capture imem_rdata with its request address into a 2-entry FIFO buffer the cycle after the request.
REQ-007 SHALL drive if_valid/if_instr/if_pc from the buffer head; if_valid=1 iff the buffer is non-empty.
REQ-008 SHALL pop the head on transfer; in the same cycle it SHALL accept a returning response, so the buffer never overflows.
REQ-009 Latency, no stall, if_ready=1: request at cycle N gives if_valid at N+1; steady state is 1 instruction per cycle.
REQ-010 On redirect_valid: fetch PC <= redirect_pc, buffer cleared, imem_req=0 in that cycle, and a response in flight from the previous cycle discarded.
REQ-011 After redirect at cycle N: imem_req=1 with imem_addr=redirect_pc at N+1, unless stalled; if_valid=0 at N+1.
REQ-012 redirect_valid SHALL take priority over stall, issue and transfer; decode flushes on the same redirect.
REQ-013 Under stall, the buffer and if_* outputs SHALL be held; a response already in flight SHALL still be captured.
REQ-014 When if_valid=1 and if_ready=0, if_instr and if_pc SHALL remain stable until transfer or redirect.
REQ-015 Redirect with redirect_pc equal to the current fetch PC SHALL still squash and refetch.

Reset
REQ-016 While rst_n=0: fetch PC=RESET_PC, buffer empty, in-flight flag 0, if_valid=0, imem_req=0, if_instr=0, if_pc=0.
REQ-017 Reset asserted mid-operation SHALL discard all buffered and in-flight data immediately.
REQ-018 First imem_req SHALL occur in the first rising edge cycle after rst_n deasserts, with imem_addr=RESET_PC.

Structure
REQ-019 PC_WIDTH, INSTR_WIDTH and RESET_PC SHALL live in cpuPkg, together with a fetch-entry struct {pc, instr}.
REQ-020 The 2-entry buffer SHALL be a sub-module fetch_buffer (push, pop, clear, full, empty, count).

Verification (PC_WIDTH=8, RESET_PC=0, memory returns instr = 0xA000 + addr)
REQ-021 Reset release, if_ready=1, no stall -> imem_addr 0,1,2,3 on consecutive cycles; if_pc 0,1,2 from the cycle after first request; if_instr 0xA000, 0xA001, 0xA002.
REQ-022 if_ready=0 for 5 cycles after reset -> at most 2 requests (addr 0,1); if_pc stays 0 with if_instr 0xA000; on release, pc 0,1,2 delivered with none lost or duplicated.
REQ-023 redirect_valid=1, redirect_pc=0x40 while addr 5 is in flight -> addr 5 never appears on if_pc; imem_addr=0x40 next cycle; if_pc=0x40 the cycle after.
REQ-024 stall=1 for 3 cycles mid-stream -> no imem_req during stall; in-flight response buffered; sequence resumes at the next PC with no gap or repeat.
REQ-025 Fetch from PC 0xFE -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-026 rst_n low for 1 cycle while buffer is full -> if_valid=0 immediately; refetch from addr 0 after release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path types and sizing for the CPU front end.
package cpuPkg;

    localparam int unsigned PC_WIDTH    = 8;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned BUF_DEPTH   = 2;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam pc_t RESET_PC = PC_WIDTH'(0);

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface fetch_stage_if;
    import cpuPkg::*;

    logic   imem_req;
    pc_t    imem_addr;
    instr_t imem_rdata;
    logic   redirect_valid;
    pc_t    redirect_pc;
    logic   stall;
    logic   if_valid;
    instr_t if_instr;
    pc_t    if_pc;
    logic   if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, redirect_valid, redirect_pc, stall, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, redirect_valid, redirect_pc, stall, if_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry fall-through FIFO of fetched {pc, instr} entries.
module fetch_buffer
    import cpuPkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_data,
    output fetch_entry_t head_c,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    localparam int unsigned CNT_W = 2;

    fetch_entry_t     mem_q [BUF_DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             bypass;
    logic             do_wr;
    logic             do_rd;

    // An arriving entry popped while the store is empty passes straight through.
    always_comb begin
        bypass = (count_q == '0) && push && pop;
        do_wr  = push && !bypass;
        do_rd  = pop && (count_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // Head shows zeros when nothing is stored or arriving.
    always_comb begin
        head_c = '0;
        if (count_q != '0) begin
            head_c = mem_q[rd_ptr_q];
        end else if (push) begin
            head_c = push_data;
        end
    end

    assign full  = (count_q == CNT_W'(BUF_DEPTH));
    assign empty = (count_q == '0) && !push;
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC sequencing, memory request issue and decode hand-off buffer.
module fetch_stage
    import cpuPkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    pc_t          pc_q;
    pc_t          req_pc_q;
    logic         inflight_q;
    logic         req_c;
    logic         push;
    logic         pop;
    logic         buf_full;
    logic         buf_empty;
    logic [1:0]   buf_count;
    logic [1:0]   occupancy;
    fetch_entry_t push_data;
    fetch_entry_t head_c;

    // Issue only while stored plus outstanding work leaves room in the buffer.
    always_comb begin
        occupancy       = buf_count + 2'(inflight_q);
        req_c           = rst_n && !bus.stall && !bus.redirect_valid
                          && !buf_full && (occupancy < 2'd2);
        push            = inflight_q && !bus.redirect_valid;
        pop             = !buf_empty && bus.if_ready && !bus.stall && !bus.redirect_valid;
        push_data.pc    = req_pc_q;
        push_data.instr = bus.imem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= req_c;
            if (bus.redirect_valid) begin
                pc_q <= bus.redirect_pc;
            end else if (req_c) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + PC_WIDTH'(1);
            end
        end
    end

    fetch_buffer u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (bus.redirect_valid),
        .push_data (push_data),
        .head_c    (head_c),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = !buf_empty;
    assign bus.if_instr  = head_c.instr;
    assign bus.if_pc     = head_c.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a queue-level reference model and directed scenarios.
module tb_fetch_stage;
    import cpuPkg::*;

    localparam int unsigned PC_MASK    = (32'd1 << PC_WIDTH) - 32'd1;
    localparam int unsigned INSTR_BASE = 32'hA000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data for the address requested this cycle appears next cycle.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? INSTR_WIDTH'(INSTR_BASE + 32'(bus.imem_addr))
                                       : INSTR_WIDTH'($urandom);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: fetch PC, one outstanding request, ordered list of undelivered PCs.
    int unsigned m_pc;
    bit          m_inf;
    int unsigned m_inf_pc;
    int unsigned m_q[$];
    int unsigned vis[$];
    int unsigned exp_next;
    int unsigned xfer_q[$];
    bit          exp_req;
    bit          exp_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
            chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
            chk("rst_if_pc", 32'(bus.if_pc), 32'd0);
            chk("rst_if_instr", 32'(bus.if_instr), 32'd0);
            m_pc     = 32'(RESET_PC);
            m_inf    = 1'b0;
            m_q.delete();
            exp_next = 32'(RESET_PC);
        end else begin
            vis = m_q;
            if (m_inf && !bus.redirect_valid) vis.push_back(m_inf_pc);
            exp_valid = (vis.size() != 0);
            exp_req   = !bus.stall && !bus.redirect_valid
                        && ((m_q.size() + (m_inf ? 1 : 0)) < 2);

            chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", 32'(bus.imem_addr), m_pc);
            chk("if_valid", 32'(bus.if_valid), 32'(exp_valid));
            if (exp_valid && bus.if_valid) begin
                chk("if_pc", 32'(bus.if_pc), vis[0]);
                chk("if_instr", 32'(bus.if_instr), INSTR_BASE + vis[0]);
            end

            // Delivered stream must be consecutive from the last reset or redirect target.
            if (bus.redirect_valid) begin
                exp_next = 32'(bus.redirect_pc);
            end else if (bus.if_valid && bus.if_ready && !bus.stall) begin
                chk("stream_pc", 32'(bus.if_pc), exp_next);
                xfer_q.push_back(32'(bus.if_pc));
                exp_next = (exp_next + 1) & PC_MASK;
            end

            if (bus.redirect_valid) begin
                m_q.delete();
                m_inf = 1'b0;
                m_pc  = 32'(bus.redirect_pc);
            end else begin
                if (exp_valid && bus.if_ready && !bus.stall) void'(vis.pop_front());
                m_q   = vis;
                m_inf = exp_req;
                if (exp_req) begin
                    m_inf_pc = m_pc;
                    m_pc     = (m_pc + 1) & PC_MASK;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int          nreq;
        bit          found;
        logic [31:0] wrap_exp [4];

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready = 1'b1;

        // Reset state, then streaming from RESET_PC.
        tick();
        @(negedge clk);
        chk("d_rst_req", 32'(bus.imem_req), 32'd0);
        chk("d_rst_valid", 32'(bus.if_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("d_stream_req", 32'(bus.imem_req), 32'd1);
            chk("d_stream_addr", 32'(bus.imem_addr), 32'(i));
            if (i > 0) begin
                chk("d_stream_pc", 32'(bus.if_pc), 32'(i - 1));
                chk("d_stream_instr", 32'(bus.if_instr), 32'hA000 + 32'(i - 1));
            end else begin
                chk("d_first_valid", 32'(bus.if_valid), 32'd0);
            end
            tick();
        end

        // Decode back-pressure right after reset.
        bus.if_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.imem_req) nreq++;
            tick();
        end
        chk("d_bp_nreq", 32'(nreq), 32'd2);
        @(negedge clk);
        chk("d_bp_valid", 32'(bus.if_valid), 32'd1);
        chk("d_bp_pc", 32'(bus.if_pc), 32'd0);
        chk("d_bp_instr", 32'(bus.if_instr), 32'hA000);
        tick();
        xfer_q.delete();
        bus.if_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("d_bp_xfer_cnt", 32'(xfer_q.size() >= 3), 32'd1);
        if (xfer_q.size() >= 3) begin
            chk("d_bp_xfer0", xfer_q[0], 32'd0);
            chk("d_bp_xfer1", xfer_q[1], 32'd1);
            chk("d_bp_xfer2", xfer_q[2], 32'd2);
        end

        // Redirect while address 5 is outstanding.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == PC_WIDTH'(5)) found = 1'b1;
            tick();
        end
        chk("d_redir_addr5_seen", 32'(found), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = PC_WIDTH'(8'h40);
        @(negedge clk);
        chk("d_redir_valid", 32'(bus.if_valid), 32'd0);
        chk("d_redir_req", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("d_redir_next_req", 32'(bus.imem_req), 32'd1);
        chk("d_redir_next_addr", 32'(bus.imem_addr), 32'h40);
        chk("d_redir_next_valid", 32'(bus.if_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("d_redir_pc", 32'(bus.if_pc), 32'h40);
        chk("d_redir_instr", 32'(bus.if_instr), 32'hA040);
        tick();

        // Three-cycle stall mid-stream.
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("d_stall_req", 32'(bus.imem_req), 32'd0);
            tick();
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // PC wrap at the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = PC_WIDTH'(8'hFE);
        tick();
        bus.redirect_valid = 1'b0;
        wrap_exp = '{32'hFE, 32'hFF, 32'h00, 32'h01};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("d_wrap_addr", 32'(bus.imem_addr), wrap_exp[i]);
            tick();
        end

        // Reset pulse with a full buffer.
        bus.if_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("d_full_valid", 32'(bus.if_valid), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("d_arst_valid", 32'(bus.if_valid), 32'd0);
        chk("d_arst_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.if_ready = 1'b1;
        @(negedge clk);
        chk("d_arst_refetch_addr", 32'(bus.imem_addr), 32'd0);
        chk("d_arst_refetch_req", 32'(bus.imem_req), 32'd1);
        tick();
        @(negedge clk);
        chk("d_arst_refetch_pc", 32'(bus.if_pc), 32'd0);
        tick();

        // Randomized traffic, including same-PC redirects and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            bus.stall = ($urandom_range(3) == 0);
            bus.if_ready = ($urandom_range(9) < 7);
            bus.redirect_valid = ($urandom_range(19) == 0);
            bus.redirect_pc = ($urandom_range(1) == 0) ? bus.imem_addr : PC_WIDTH'($urandom);
            rst_n = ($urandom_range(299) != 0);
            tick();
        end
        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
